// File: rtl/sv_latch_capture_fifo.sv
// sv_latch_capture_fifo
// Samples a registered-latch word into a small first-word-fall-through FIFO
// whenever a capture is requested. Requests arriving while the FIFO is full are
// dropped and recorded in a sticky overflow flag.
//
// Optional feature: define CHANGE_DETECT_EN to also raise a capture request
// whenever data_in differs from its value on the previous clock edge.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   reset         asynchronous active-high reset
//   data_in       word to capture (WIDTH bits)
//   capture       single-cycle capture request
//   out_ready     consumer ready; pops the head entry when out_valid is high
//   overflow_clr  clears the sticky overflow flag
//   out_valid     head entry valid (level != 0)
//   out_data      head entry, combinational from storage
//   level         current entry count, 0..DEPTH
//   full          level == DEPTH
//   overflow      sticky flag, a request was dropped
module sv_latch_capture_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     capture,
    input  logic                     out_ready,
    input  logic                     overflow_clr,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          out_valid_q, out_valid_d;
    logic          overflow_q, overflow_d;

    logic          req_c;
    logic          push_c;
    logic          pop_c;
    logic          drop_c;

`ifdef CHANGE_DETECT_EN
    logic [WIDTH-1:0] prev_data_q, prev_data_d;
    logic             change_c;

    // A new value on the latch output counts as a capture request.
    always_comb begin
        prev_data_d = data_in;
        change_c    = (data_in != prev_data_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_data_q <= '0;
        end else begin
            prev_data_q <= prev_data_d;
        end
    end
`endif

    // Request, push/pop/drop qualification and next-state computation.
    always_comb begin
`ifdef CHANGE_DETECT_EN
        req_c = capture | change_c;
`else
        req_c = capture;
`endif
        push_c = req_c & ~full_q;
        drop_c = req_c & full_q;
        pop_c  = out_valid_q & out_ready;

        // DEPTH is a power of two, so the natural AW-bit wrap gives DEPTH-1 -> 0.
        wr_ptr_d    = push_c ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_c  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        level_d     = level_q + LW'(push_c) - LW'(pop_c);
        full_d      = (level_d == LW'(DEPTH));
        out_valid_d = (level_d != '0);

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (push_c && !reset) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = out_valid_q;
    assign level     = level_q;
    assign full      = full_q;
    assign overflow  = overflow_q;

endmodule
